// File: rtl/mem_stage_mq_if.sv
// Handshake and data bundle between EX, the memory stage, the data-SRAM response side and WB.
// The memory stage connects through the slave modport; whoever drives it uses the master modport.
interface mem_stage_mq_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int EXC_W  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              es_to_ms_valid;
  logic              ms_allowin;
  logic [31:0]       es_pc;
  logic              es_mem_req;
  logic              es_res_from_mem;
  logic [1:0]        es_ld_size;
  logic              es_ld_sign;
  logic              es_rf_we;
  logic [4:0]        es_rf_waddr;
  logic [DATA_W-1:0] es_result;
  logic [EXC_W-1:0]  es_except;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              except_flush;
  logic              ws_allowin;
  logic              ms_to_ws_valid;
  logic [31:0]       ms_pc;
  logic              ms_rf_we;
  logic [4:0]        ms_rf_waddr;
  logic [DATA_W-1:0] ms_rf_wdata;
  logic [EXC_W-1:0]  ms_except;
  logic              ms_ld_pending;
  logic [CNT_W-1:0]  ms_count;

  modport master (
    output es_to_ms_valid, es_pc, es_mem_req, es_res_from_mem, es_ld_size, es_ld_sign,
           es_rf_we, es_rf_waddr, es_result, es_except, data_sram_data_ok, data_sram_rdata,
           except_flush, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           ms_except, ms_ld_pending, ms_count
  );

  modport slave (
    input  es_to_ms_valid, es_pc, es_mem_req, es_res_from_mem, es_ld_size, es_ld_sign,
           es_rf_we, es_rf_waddr, es_result, es_except, data_sram_data_ok, data_sram_rdata,
           except_flush, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           ms_except, ms_ld_pending, ms_count
  );
endinterface

// File: rtl/mem_stage_mq.sv
// Memory stage holding up to DEPTH in-order loads/stores between EX and WB; data_ok responses
// are matched to slots in issue order and responses owed to flushed requests are discarded.
module mem_stage_mq #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int EXC_W  = 16
) (
  input  logic          clk,
  input  logic          resetn,
  mem_stage_mq_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DSC_W = PTR_W + 2;
  localparam int OFF_W = $clog2(DATA_W / 8);

  // Shift the addressed lane down, then truncate to the access size and extend.
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [DATA_W-1:0] data,
    input logic [OFF_W-1:0]  off,
    input logic [1:0]        size,
    input logic              sign
  );
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] b_res;
    logic [DATA_W-1:0] h_res;
    logic [DATA_W-1:0] w_res;
    logic [DATA_W-1:0] res;
    lane  = data >> {off, 3'b000};
    b_res = sign ? DATA_W'($signed(lane[7:0]))  : DATA_W'(lane[7:0]);
    h_res = sign ? DATA_W'($signed(lane[15:0])) : DATA_W'(lane[15:0]);
    w_res = sign ? DATA_W'($signed(lane[31:0])) : DATA_W'(lane[31:0]);
    case (size)
      2'd0:    res = b_res;
      2'd1:    res = h_res;
      2'd2:    res = w_res;
      2'd3:    res = (DATA_W == 64) ? lane : w_res;
      default: res = w_res;
    endcase
    return res;
  endfunction

  logic [31:0]       pc_r     [DEPTH];
  logic [1:0]        size_r   [DEPTH];
  logic [4:0]        waddr_r  [DEPTH];
  logic [DATA_W-1:0] result_r [DEPTH];
  logic [EXC_W-1:0]  except_r [DEPTH];
  logic [DATA_W-1:0] data_r   [DEPTH];
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  wait_r;
  logic [DEPTH-1:0]  got_r;
  logic [DEPTH-1:0]  rfm_r;
  logic [DEPTH-1:0]  sign_r;
  logic [DEPTH-1:0]  we_r;
  logic [PTR_W-1:0]  hp_r;
  logic [PTR_W-1:0]  tp_r;
  logic [CNT_W-1:0]  count_r;
  logic [DSC_W-1:0]  discard_r;

  logic [DEPTH-1:0]  owed_s;
  logic [DEPTH-1:0]  owed_after_s;
  logic              rp_found_s;
  logic [PTR_W-1:0]  rp_s;
  logic              disc_hit_s;
  logic              route_s;
  logic              head_valid_s;
  logic              head_bypass_s;
  logic              head_done_s;
  logic [DATA_W-1:0] head_data_s;
  logic [DATA_W-1:0] head_wdata_s;
  logic              deq_s;
  logic              enq_s;
  logic              allowin_s;
  logic [DSC_W-1:0]  flush_owed_s;
  logic [DSC_W-1:0]  discard_nxt_s;

  assign owed_s = valid_r & wait_r & ~got_r;

  // Oldest slot still owed a response, searched from the head in age order.
  always_comb begin
    rp_found_s = 1'b0;
    rp_s       = hp_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rp_found_s && owed_s[hp_r + PTR_W'(i)]) begin
        rp_found_s = 1'b1;
        rp_s       = hp_r + PTR_W'(i);
      end else begin
        rp_found_s = rp_found_s;
      end
    end
  end

  assign disc_hit_s    = bus.data_sram_data_ok & (discard_r != {DSC_W{1'b0}});
  assign route_s       = bus.data_sram_data_ok & ~disc_hit_s & rp_found_s;
  assign head_valid_s  = valid_r[hp_r];
  assign head_bypass_s = route_s & (rp_s == hp_r);
  assign head_done_s   = head_valid_s & (~wait_r[hp_r] | got_r[hp_r] |
                                         (|except_r[hp_r]) | head_bypass_s);
  assign head_data_s   = head_bypass_s ? bus.data_sram_rdata : data_r[hp_r];
  assign head_wdata_s  = rfm_r[hp_r]
                         ? load_extend(head_data_s, result_r[hp_r][OFF_W-1:0],
                                       size_r[hp_r], sign_r[hp_r])
                         : result_r[hp_r];
  assign deq_s         = head_done_s & bus.ws_allowin;
  assign allowin_s     = (count_r < CNT_W'(DEPTH)) | deq_s;
  assign enq_s         = bus.es_to_ms_valid & allowin_s & ~bus.except_flush;

  // Requests still owed after this cycle's routing become the discard debt on a flush.
  always_comb begin
    owed_after_s = owed_s;
    if (route_s) begin
      owed_after_s[rp_s] = 1'b0;
    end else begin
      owed_after_s = owed_s;
    end
    flush_owed_s = {DSC_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      flush_owed_s = flush_owed_s + DSC_W'(owed_after_s[i]);
    end
    discard_nxt_s = discard_r - DSC_W'(disc_hit_s);
    if (bus.except_flush) begin
      discard_nxt_s = discard_nxt_s + flush_owed_s;
    end else begin
      discard_nxt_s = discard_nxt_s;
    end
  end

  // Slot storage, pointers, occupancy and discard counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r   <= {DEPTH{1'b0}};
      wait_r    <= {DEPTH{1'b0}};
      got_r     <= {DEPTH{1'b0}};
      rfm_r     <= {DEPTH{1'b0}};
      sign_r    <= {DEPTH{1'b0}};
      we_r      <= {DEPTH{1'b0}};
      hp_r      <= {PTR_W{1'b0}};
      tp_r      <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      discard_r <= {DSC_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_r[i]     <= 32'h0000_0000;
        size_r[i]   <= 2'd0;
        waddr_r[i]  <= 5'd0;
        result_r[i] <= {DATA_W{1'b0}};
        except_r[i] <= {EXC_W{1'b0}};
        data_r[i]   <= {DATA_W{1'b0}};
      end
    end else begin
      discard_r <= discard_nxt_s;
      if (bus.except_flush) begin
        valid_r <= {DEPTH{1'b0}};
        hp_r    <= {PTR_W{1'b0}};
        tp_r    <= {PTR_W{1'b0}};
        count_r <= {CNT_W{1'b0}};
      end else begin
        if (route_s) begin
          got_r[rp_s]  <= 1'b1;
          data_r[rp_s] <= bus.data_sram_rdata;
        end
        if (deq_s) begin
          valid_r[hp_r] <= 1'b0;
          hp_r          <= hp_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        // Enqueue is last so a full-queue replace of the head slot wins over the drain.
        if (enq_s) begin
          valid_r[tp_r]  <= 1'b1;
          wait_r[tp_r]   <= bus.es_mem_req & (bus.es_except == {EXC_W{1'b0}});
          got_r[tp_r]    <= 1'b0;
          rfm_r[tp_r]    <= bus.es_res_from_mem;
          sign_r[tp_r]   <= bus.es_ld_sign;
          we_r[tp_r]     <= bus.es_rf_we;
          pc_r[tp_r]     <= bus.es_pc;
          size_r[tp_r]   <= bus.es_ld_size;
          waddr_r[tp_r]  <= bus.es_rf_waddr;
          result_r[tp_r] <= bus.es_result;
          except_r[tp_r] <= bus.es_except;
          data_r[tp_r]   <= {DATA_W{1'b0}};
          tp_r           <= tp_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        count_r <= count_r + {{(CNT_W-1){1'b0}}, enq_s} - {{(CNT_W-1){1'b0}}, deq_s};
      end
    end
  end

  assign bus.ms_allowin     = allowin_s;
  assign bus.ms_to_ws_valid = head_done_s;
  assign bus.ms_pc          = head_valid_s ? pc_r[hp_r] : 32'h0000_0000;
  assign bus.ms_rf_we       = we_r[hp_r] & head_done_s;
  assign bus.ms_rf_waddr    = head_valid_s ? waddr_r[hp_r] : 5'd0;
  assign bus.ms_rf_wdata    = head_valid_s ? head_wdata_s : {DATA_W{1'b0}};
  assign bus.ms_except      = head_valid_s ? except_r[hp_r] : {EXC_W{1'b0}};
  assign bus.ms_ld_pending  = |owed_s;
  assign bus.ms_count       = count_r;
endmodule
